// File: rtl/win_pkg.sv
// Shared types and defaults for the window framer and the window block it feeds.
// Shared by win_framer and its bench.
package win_pkg;

  localparam int DwidthDef = 16;
  localparam int NwinDef   = 32;
  localparam int IwidthDef = 5;

  typedef struct packed {
    logic [DwidthDef-1:0] re;
    logic [DwidthDef-1:0] im;
  } cplx_t;

  typedef logic [IwidthDef-1:0] win_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/win_framer.sv
// Frames a valid/ready complex sample stream into indexed windows of Nwin samples.
// Optional macro WIN_FRAMER_TESTPAT_EN adds a testpat input that substitutes an index ramp.
module win_framer
  import win_pkg::*;
#(
  parameter int Dwidth = DwidthDef,
  parameter int Nwin   = NwinDef,
  parameter int Iwidth = IwidthDef,
  parameter int Ngap   = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
`ifdef WIN_FRAMER_TESTPAT_EN
  input  logic              testpat,
`endif
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [Dwidth-1:0] s_real,
  input  logic [Dwidth-1:0] s_imag,
  output logic              dv_out,
  output logic [Iwidth-1:0] index_out,
  output logic [Dwidth-1:0] dout_real,
  output logic [Dwidth-1:0] dout_imag,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam int GW = (Ngap > 1) ? $clog2(Ngap) : 1;

  state_t            r_state;
  logic [Iwidth-1:0] r_idx;
  logic [GW-1:0]     r_gap;
  logic              r_dv;
  logic [Iwidth-1:0] r_index;
  logic [Dwidth-1:0] r_real;
  logic [Dwidth-1:0] r_imag;
  logic              r_done;
  logic [15:0]       r_cnt;

  logic              w_accept;
  logic              w_last;
  logic [Dwidth-1:0] w_din_real;
  logic [Dwidth-1:0] w_din_imag;

  assign s_ready  = (r_state == RUN);
  assign busy     = (r_state != IDLE);
  assign w_accept = s_valid && s_ready;
  assign w_last   = (r_idx == Iwidth'(Nwin - 1));

`ifdef WIN_FRAMER_TESTPAT_EN
  // Ramp places the index in the top bits so it spans the full signed range.
  logic [Dwidth-1:0] w_pat;
  assign w_pat      = Dwidth'(r_idx) << (Dwidth - Iwidth);
  assign w_din_real = testpat ? w_pat  : s_real;
  assign w_din_imag = testpat ? -w_pat : s_imag;
`else
  assign w_din_real = s_real;
  assign w_din_imag = s_imag;
`endif

  // enable is only looked at in IDLE and at frame end, so frames are never cut short.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_gap   <= '0;
      r_dv    <= 1'b0;
      r_index <= '0;
      r_real  <= '0;
      r_imag  <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_dv   <= w_accept;
      r_done <= 1'b0;
      if (w_accept) begin
        r_index <= r_idx;
        r_real  <= w_din_real;
        r_imag  <= w_din_imag;
        r_idx   <= r_idx + Iwidth'(1);
      end
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= RUN;
            r_idx   <= '0;
          end
        end
        RUN: begin
          if (w_accept && w_last) begin
            r_done <= 1'b1;
            r_cnt  <= r_cnt + 16'd1;
            if (Ngap > 0) begin
              r_state <= GAP;
              r_gap   <= GW'(Ngap - 1);
            end else if (!enable) begin
              r_state <= IDLE;
            end
          end
        end
        GAP: begin
          if (r_gap == '0) begin
            r_state <= enable ? RUN : IDLE;
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dv_out     = r_dv;
  assign index_out  = r_index;
  assign dout_real  = r_real;
  assign dout_imag  = r_imag;
  assign frame_done = r_done;
  assign frame_cnt  = r_cnt;

endmodule

// File: tb/tb_win_framer.sv
// Directed bench for win_framer: back-to-back frames, stalls, enable drop, async reset, gaps.
// Test-pattern checks are included when WIN_FRAMER_TESTPAT_EN is defined.
module tb_win_framer;
  import win_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic        en_g = 1'b0;
  logic        val_g = 1'b0;
  logic        testpat = 1'b0;
  logic [15:0] s_real = '0;
  logic [15:0] s_imag = '0;

  logic        s_ready, dv_out, frame_done, busy;
  logic [4:0]  index_out;
  logic [15:0] dout_real, dout_imag, frame_cnt;

  logic        g_s_ready, g_dv, g_done, g_busy;
  logic [4:0]  g_index;
  logic [15:0] g_real, g_imag, g_cnt;

  int nAssert = 0;
  int nFail = 0;

  int          expIdx = 0;
  int          expCnt = 0;
  int          lastIdx = 0;
  logic [15:0] lastReal = '0;
  logic [15:0] lastImag = '0;
  logic [15:0] nextReal = 16'h1000;
  logic [15:0] nextImag = 16'hA000;

  win_framer #(.Dwidth(16), .Nwin(32), .Iwidth(5), .Ngap(0)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
`ifdef WIN_FRAMER_TESTPAT_EN
    .testpat(testpat),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .dv_out(dv_out), .index_out(index_out), .dout_real(dout_real), .dout_imag(dout_imag),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
  );

  win_framer #(.Dwidth(16), .Nwin(32), .Iwidth(5), .Ngap(3)) dutg (
    .clk(clk), .resetn(resetn), .enable(en_g),
`ifdef WIN_FRAMER_TESTPAT_EN
    .testpat(1'b0),
`endif
    .s_valid(val_g), .s_ready(g_s_ready), .s_real(s_real), .s_imag(s_imag),
    .dv_out(g_dv), .index_out(g_index), .dout_real(g_real), .dout_imag(g_imag),
    .frame_done(g_done), .frame_cnt(g_cnt), .busy(g_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock on the Ngap=0 framer; expAcc says whether the model expects this sample taken.
  task automatic applyStimulus(input logic v, input logic expAcc);
    logic expDone;
    s_valid = v;
    s_real  = nextReal;
    s_imag  = nextImag;
    step();
    expDone = 1'b0;
    if (expAcc) begin
      lastIdx  = expIdx;
      lastReal = nextReal;
      lastImag = nextImag;
      expDone  = (expIdx == 31);
      if (expDone) expCnt = (expCnt + 1) % 65536;
      expIdx   = (expIdx + 1) % 32;
      nextReal = nextReal + 16'h0101;
      nextImag = nextImag - 16'h0033;
    end
    checkOutput("dv_out", 32'(dv_out), 32'(expAcc));
    checkOutput("index_out", 32'(index_out), 32'(lastIdx));
    checkOutput("dout_real", 32'(dout_real), 32'(lastReal));
    checkOutput("dout_imag", 32'(dout_imag), 32'(lastImag));
    checkOutput("frame_done", 32'(frame_done), 32'(expDone));
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(expCnt));
  endtask

  initial begin
    logic [9:0] pattern;
    pattern = 10'b0100110101;

    // Reset values
    #3;
    checkOutput("rst dv_out", 32'(dv_out), 32'd0);
    checkOutput("rst index_out", 32'(index_out), 32'd0);
    checkOutput("rst frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    step();
    resetn = 1'b1;
    step();
    checkOutput("idle s_ready", 32'(s_ready), 32'd0);

    // Continuous valid, back-to-back frames
    enable = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("run s_ready", 32'(s_ready), 32'd1);
    checkOutput("run busy", 32'(busy), 32'd1);
    for (int k = 0; k < 64; k++) applyStimulus(1'b1, 1'b1);
    checkOutput("two frames cnt", 32'(frame_cnt), 32'd2);

    // Stalled valid: dv mirrors valid, index never skips
    for (int j = 0; j < 10; j++) applyStimulus(pattern[j], pattern[j]);

    // Enable drop at index 10: frame still completes
    while (lastIdx != 10) applyStimulus(1'b1, 1'b1);
    enable = 1'b0;
    while (expIdx != 0) applyStimulus(1'b1, 1'b1);
    checkOutput("drop s_ready", 32'(s_ready), 32'd0);
    checkOutput("drop busy", 32'(busy), 32'd0);
    checkOutput("drop cnt", 32'(frame_cnt), 32'd3);
    applyStimulus(1'b1, 1'b0);
    checkOutput("idle busy", 32'(busy), 32'd0);

    // Async reset in the middle of a frame
    enable = 1'b1;
    applyStimulus(1'b1, 1'b0);
    while (lastIdx != 20) applyStimulus(1'b1, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("arst dv_out", 32'(dv_out), 32'd0);
    checkOutput("arst index_out", 32'(index_out), 32'd0);
    checkOutput("arst dout_real", 32'(dout_real), 32'd0);
    checkOutput("arst dout_imag", 32'(dout_imag), 32'd0);
    checkOutput("arst frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("arst s_ready", 32'(s_ready), 32'd0);
    checkOutput("arst busy", 32'(busy), 32'd0);
    expIdx = 0; expCnt = 0; lastIdx = 0; lastReal = '0; lastImag = '0;
    #2;
    resetn = 1'b1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);

`ifdef WIN_FRAMER_TESTPAT_EN
    testpat = 1'b1;
    s_valid = 1'b1;
    step();
    checkOutput("tp idx1 index", 32'(index_out), 32'd1);
    checkOutput("tp idx1 real", 32'(dout_real), 32'h0800);
    checkOutput("tp idx1 imag", 32'(dout_imag), 32'hF800);
    for (int k = 2; k < 32; k++) step();
    checkOutput("tp idx31 index", 32'(index_out), 32'd31);
    checkOutput("tp idx31 real", 32'(dout_real), 32'hF800);
    checkOutput("tp idx31 imag", 32'(dout_imag), 32'h0800);
    testpat = 1'b0;
`endif

    // Ngap=3 instance: three idle cycles between frames
    s_valid = 1'b0;
    en_g = 1'b1;
    val_g = 1'b1;
    step();
    checkOutput("gap run s_ready", 32'(g_s_ready), 32'd1);
    checkOutput("gap run dv", 32'(g_dv), 32'd0);
    for (int k = 0; k < 32; k++) begin
      step();
      checkOutput("gap frame dv", 32'(g_dv), 32'd1);
      checkOutput("gap frame index", 32'(g_index), 32'(k));
      checkOutput("gap frame_done", 32'(g_done), 32'(k == 31));
    end
    checkOutput("gap s_ready 1", 32'(g_s_ready), 32'd0);
    checkOutput("gap cnt", 32'(g_cnt), 32'd1);
    for (int k = 0; k < 2; k++) begin
      step();
      checkOutput("gap dv low", 32'(g_dv), 32'd0);
      checkOutput("gap s_ready low", 32'(g_s_ready), 32'd0);
      checkOutput("gap busy", 32'(g_busy), 32'd1);
    end
    step();
    checkOutput("gap exit dv", 32'(g_dv), 32'd0);
    checkOutput("gap exit s_ready", 32'(g_s_ready), 32'd1);
    step();
    checkOutput("gap next dv", 32'(g_dv), 32'd1);
    checkOutput("gap next index", 32'(g_index), 32'd0);
    checkOutput("gap next cnt", 32'(g_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
